rc4_key_dispatcher: RTL and testbench

//  Central scheduler for the parallel RC4 key search. Hands out successive secret keys
//  to NUM_CORES search cores (each runs identity -> KSA -> decrypt-check), tracks keys
//  in flight, and detects the first core reporting a valid decryption. On success it

---
 rtl/rc4_key_dispatcher.sv | 174 +++++++++++++++++
 tb/tb_rc4_key_dispatcher.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_dispatcher.sv
// rc4_key_dispatcher: hands successive RC4 secret keys to a pool of search
// cores round-robin, counts keys in flight, latches the first reported
// solution and broadcasts stop, or flags exhaustion once the key space drains.
module rc4_key_dispatcher #(
   parameter int               NUM_CORES = 4,
   parameter int               KEY_W     = 24,
   parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
   parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [NUM_CORES-1:0]       core_req,
   input  logic [NUM_CORES-1:0]       core_done,
   input  logic [NUM_CORES-1:0]       core_found,
   input  logic [NUM_CORES*KEY_W-1:0] core_key,
   output logic [NUM_CORES-1:0]       grant,
   output logic [KEY_W-1:0]           grant_key,
   output logic                       stop,
   output logic                       found,
   output logic [KEY_W-1:0]           found_key,
   output logic                       exhausted,
   output logic                       busy
);

   localparam int IDX_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int OUT_W   = $clog2(NUM_CORES + 1);
   localparam int OUT_MAX = (1 << OUT_W) - 1;

   typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED} state_t;

   state_t               state_reg;
   logic [KEY_W-1:0]     next_key_reg;
   logic [IDX_W-1:0]     rr_ptr_reg;
   logic [OUT_W-1:0]     outstanding_reg;
   logic [NUM_CORES-1:0] grant_reg;
   logic [KEY_W-1:0]     grant_key_reg;
   logic                 stop_reg;
   logic                 found_reg;
   logic [KEY_W-1:0]     found_key_reg;
   logic                 exhausted_reg;

   logic [KEY_W-1:0]     core_key_arr [NUM_CORES];
   logic [NUM_CORES-1:0] eligible;
   logic [NUM_CORES-1:0] hit;
   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     win_idx;
   logic                 grant_fire;
   logic [OUT_W-1:0]     outstanding_next;
   int                   done_cnt;
   int                   out_sum;

   // Split the flat key bus into one key per core.
   generate
      for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_key_split
         assign core_key_arr[gi] = core_key[gi*KEY_W +: KEY_W];
      end
   endgenerate

   // Cores granted last cycle are masked so a lingering request is not re-served.
   assign eligible   = core_req & ~grant_reg;
   assign hit        = core_done & core_found;
   assign grant_fire = (state_reg == DISPATCH) && !(|hit) && pick_valid;

   // Round-robin pick: first eligible core at or above rr_ptr, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!pick_valid && eligible[(int'(rr_ptr_reg) + i) % NUM_CORES]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'((int'(rr_ptr_reg) + i) % NUM_CORES);
         end
      end
   end

   // Lowest-index core reporting a valid decryption wins a simultaneous find.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (hit[i]) win_idx = IDX_W'(i);
      end
   end

   // Keys in flight: +1 per grant, -1 per done bit, clamped so it never wraps.
   always_comb begin
      done_cnt = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (core_done[i]) done_cnt++;
      end
      out_sum = int'(outstanding_reg) + (grant_fire ? 1 : 0) - done_cnt;
      if (out_sum < 0)            out_sum = 0;
      else if (out_sum > OUT_MAX) out_sum = OUT_MAX;
      outstanding_next = OUT_W'(out_sum);
   end

   // Dispatcher state machine with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         next_key_reg    <= KEY_START;
         rr_ptr_reg      <= '0;
         outstanding_reg <= '0;
         grant_reg       <= '0;
         grant_key_reg   <= '0;
         stop_reg        <= 1'b0;
         found_reg       <= 1'b0;
         found_key_reg   <= '0;
         exhausted_reg   <= 1'b0;
      end else begin
         grant_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  next_key_reg    <= KEY_START;
                  rr_ptr_reg      <= '0;
                  outstanding_reg <= '0;
                  state_reg       <= DISPATCH;
               end
            end
            DISPATCH: begin
               outstanding_reg <= outstanding_next;
               if (|hit) begin
                  found_reg     <= 1'b1;
                  stop_reg      <= 1'b1;
                  found_key_reg <= core_key_arr[win_idx];
                  state_reg     <= FOUND;
               end else if (pick_valid) begin
                  grant_reg     <= NUM_CORES'(1) << pick_idx;
                  grant_key_reg <= next_key_reg;
                  next_key_reg  <= next_key_reg + 1'b1;
                  rr_ptr_reg    <= (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
                  // The last key ends dispatching; the counter never wraps to 0.
                  if (next_key_reg == KEY_LAST) state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               outstanding_reg <= outstanding_next;
               if (|hit) begin
                  found_reg     <= 1'b1;
                  stop_reg      <= 1'b1;
                  found_key_reg <= core_key_arr[win_idx];
                  state_reg     <= FOUND;
               end else if (outstanding_next == '0) begin
                  exhausted_reg <= 1'b1;
                  state_reg     <= EXHAUSTED;
               end
            end
            FOUND, EXHAUSTED: begin
               if (start) begin
                  found_reg       <= 1'b0;
                  exhausted_reg   <= 1'b0;
                  stop_reg        <= 1'b0;
                  next_key_reg    <= KEY_START;
                  rr_ptr_reg      <= '0;
                  outstanding_reg <= '0;
                  state_reg       <= DISPATCH;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign grant     = grant_reg;
   assign grant_key = grant_key_reg;
   assign stop      = stop_reg;
   assign found     = found_reg;
   assign found_key = found_key_reg;
   assign exhausted = exhausted_reg;
   assign busy      = (state_reg == DISPATCH) || (state_reg == DRAIN);

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// tb_rc4_key_dispatcher: directed checks of the key dispatcher with a short
// key space (KEY_LAST = 5) so drain and exhaustion are reached quickly.
module tb_rc4_key_dispatcher;

   localparam int NC = 4;
   localparam int KW = 24;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [NC-1:0]  core_req;
   logic [NC-1:0]  core_done;
   logic [NC-1:0]  core_found;
   logic [NC*KW-1:0] core_key;
   logic [NC-1:0]  grant;
   logic [KW-1:0]  grant_key;
   logic           stop;
   logic           found;
   logic [KW-1:0]  found_key;
   logic           exhausted;
   logic           busy;

   int n_checks = 0;
   int n_pass   = 0;

   rc4_key_dispatcher #(
      .NUM_CORES (NC),
      .KEY_W     (KW),
      .KEY_START (24'h000000),
      .KEY_LAST  (24'h000005)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .core_req   (core_req),
      .core_done  (core_done),
      .core_found (core_found),
      .core_key   (core_key),
      .grant      (grant),
      .grant_key  (grant_key),
      .stop       (stop),
      .found      (found),
      .found_key  (found_key),
      .exhausted  (exhausted),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // One comparison: count it, print one line for it.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("[%0t] ok   %s = 0x%0h", $time, tag, got);
      end else begin
         $display("[%0t] FAIL %s: got 0x%0h expected 0x%0h", $time, tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0;
      core_req = '0; core_done = '0; core_found = '0; core_key = '0;
      tick; tick;
      check("rst_grant",     32'(grant),     32'h0);
      check("rst_grant_key", 32'(grant_key), 32'h0);
      check("rst_found",     32'(found),     32'h0);
      check("rst_stop",      32'(stop),      32'h0);
      check("rst_exhausted", 32'(exhausted), 32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      reset = 1'b0;
      tick;

      // T1: four requesting cores get keys 0..3 in round-robin order
      start = 1'b1; tick; start = 1'b0;
      core_req = 4'b1111;
      check("t1_busy",    32'(busy),  32'h1);
      check("t1_nogrant", 32'(grant), 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick;
         check($sformatf("t1_grant%0d", i), 32'(grant),     32'(1 << i));
         check($sformatf("t1_key%0d", i),   32'(grant_key), 32'(i));
      end
      core_req = 4'b0001;
      tick;
      check("t1_wrap_grant", 32'(grant),     32'h1);
      check("t1_wrap_key",   32'(grant_key), 32'h4);
      tick;
      check("t1_masked", 32'(grant), 32'h0);
      core_req = '0;

      // T2: core 2 reports a find while others request -> no grant, found latched
      core_req = 4'b1111; core_done = 4'b0100; core_found = 4'b0100;
      core_key[2*KW +: KW] = 24'h00A1B2;
      tick;
      core_done = '0; core_found = '0;
      check("t2_found",     32'(found),     32'h1);
      check("t2_stop",      32'(stop),      32'h1);
      check("t2_found_key", 32'(found_key), 32'h00A1B2);
      check("t2_grant",     32'(grant),     32'h0);
      check("t2_busy",      32'(busy),      32'h0);
      tick;
      check("t2_hold_grant", 32'(grant), 32'h0);
      check("t2_hold_stop",  32'(stop),  32'h1);

      // T3: restart, then cores 1 and 3 find together; core 0 done without a find
      core_req = '0;
      start = 1'b1; tick; start = 1'b0;
      check("t3_found_clr", 32'(found), 32'h0);
      check("t3_stop_clr",  32'(stop),  32'h0);
      check("t3_busy",      32'(busy),  32'h1);
      core_key = '0;
      core_key[0*KW +: KW] = 24'h000009;
      core_key[1*KW +: KW] = 24'h000005;
      core_key[3*KW +: KW] = 24'h000007;
      core_done = 4'b1011; core_found = 4'b1010;
      tick;
      core_done = '0; core_found = '0;
      check("t3_found",     32'(found),     32'h1);
      check("t3_found_key", 32'(found_key), 32'h5);

      // T4/T5: two cores walk the key space 0..5, then drain to exhaustion
      start = 1'b1; tick; start = 1'b0;
      core_done = 4'b0011;            // done with nothing outstanding: must not wrap
      tick;
      core_done = '0;
      check("t5_under_grant", 32'(grant), 32'h0);
      core_req = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) core_done = 4'b0100;   // done by another core alongside a grant
         tick;
         core_done = '0;
         check($sformatf("t4_grant%0d", i), 32'(grant),     (i % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("t4_key%0d", i),   32'(grant_key), 32'(i));
      end
      tick;
      check("t4_drain_nogrant", 32'(grant),     32'h0);
      check("t4_drain_busy",    32'(busy),      32'h1);
      check("t4_drain_exh",     32'(exhausted), 32'h0);
      core_req = '0;
      // Five keys remain in flight (six grants, one early done).
      core_done = 4'b0011; tick;
      check("t4_exh_after2", 32'(exhausted), 32'h0);
      core_done = 4'b0001; tick;
      check("t4_exh_after3", 32'(exhausted), 32'h0);
      tick;
      check("t4_exh_after4", 32'(exhausted), 32'h0);
      check("t4_busy_after4", 32'(busy),     32'h1);
      tick;
      core_done = '0;
      check("t4_exhausted", 32'(exhausted), 32'h1);
      check("t4_busy_drop", 32'(busy),      32'h0);
      tick;
      check("t4_exh_hold",  32'(exhausted), 32'h1);
      check("t4_no_found",  32'(found),     32'h0);

      // T6: asynchronous reset in the middle of dispatching
      start = 1'b1; tick; start = 1'b0;
      check("t6_exh_clr", 32'(exhausted), 32'h0);
      core_req = 4'b1111;
      tick; tick;
      check("t6_pre_grant", 32'(grant),     32'h2);
      check("t6_pre_key",   32'(grant_key), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_grant", 32'(grant),     32'h0);
      check("t6_async_key",   32'(grant_key), 32'h0);
      check("t6_async_busy",  32'(busy),      32'h0);
      tick;
      reset = 1'b0; core_req = '0;
      start = 1'b1; tick; start = 1'b0;
      core_req = 4'b0100;
      tick;
      check("t6_restart_grant", 32'(grant),     32'h4);
      check("t6_restart_key",   32'(grant_key), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
